sb_spin_readout: RTL



---
 rtl/sb_pkg.sv | 15 +
 rtl/sb_popcount.sv | 18 +
 rtl/sb_spin_readout.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared types for the simulated-bifurcation readout: FSM states and the spin-vector
// convention (bit = 1 means spin +1, bit = 0 means spin -1).
package sb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } sb_state_t;

    localparam int SB_N = 8;

    typedef logic [SB_N-1:0] spin_vec_t;

endpackage

// File: rtl/sb_popcount.sv
// Combinational population count of a per-oscillator collision mask.
module sb_popcount #(
    parameter int N = 8
) (
    input  logic [N-1:0]             mask,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int CW = $clog2(N+1);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(mask[i]);
        end
    end

endmodule

// File: rtl/sb_spin_readout.sv
// Terminal reader of the oscillator pipeline: tracks per-oscillator signs until they
// hold steady or the iteration budget expires, then presents the spin vector.
module sb_spin_readout
    import sb_pkg::*;
#(
    parameter int N            = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int FRAC_WIDTH   = 16,
    parameter int STABLE_ITERS = 16,
    parameter int ITER_WIDTH   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ITER_WIDTH-1:0]                 max_iters,
    input  logic                                  valid_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]          x_in,
    input  logic [N-1:0]                          collision_mask_in,
    output logic [N-1:0]                          spins_out,
    output logic                                  spins_valid,
    input  logic                                  spins_ready,
    output logic                                  converged,
    output logic [ITER_WIDTH-1:0]                 iter_count,
    output logic [ITER_WIDTH+$clog2(N+1)-1:0]     total_collisions,
    output logic                                  busy
);

    localparam int CW = $clog2(N+1);
    localparam int TW = ITER_WIDTH + CW;
    localparam int SW = $clog2(STABLE_ITERS+1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_ITERS);

    sb_state_t             state, state_next;
    logic [ITER_WIDTH-1:0] max_lat;
    logic [N-1:0]          prev_s, s;
    logic                  have_prev;
    logic [SW-1:0]         stable_cnt, stable_inc;
    logic [ITER_WIDTH-1:0] iter_inc;
    logic [TW:0]           coll_sum;
    logic [TW-1:0]         coll_inc;
    logic [CW-1:0]         pop_cnt;
    logic                  stop_a, stop_b;

    // Only the sign bit of each position matters here; the rest is consumed upstream.
    logic unused_bits;
    assign unused_bits = ^{x_in, FRAC_WIDTH[0]};

    sb_popcount #(.N(N)) u_popcount (
        .mask  (collision_mask_in),
        .count (pop_cnt)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        s = '0;
        for (int i = 0; i < N; i++) begin
            s[i] = ~x_in[i][DATA_WIDTH-1];
        end

        iter_inc = (&iter_count) ? iter_count : iter_count + ITER_WIDTH'(1);
        coll_sum = {1'b0, total_collisions} + (TW+1)'(pop_cnt);
        coll_inc = coll_sum[TW] ? {TW{1'b1}} : coll_sum[TW-1:0];

        if (!have_prev || s != prev_s)    stable_inc = '0;
        else if (stable_cnt == STABLE_MAX) stable_inc = stable_cnt;
        else                               stable_inc = stable_cnt + SW'(1);

        stop_a = (stable_inc == STABLE_MAX);
        stop_b = (max_lat != '0) && (iter_inc == max_lat);

        state_next = state;
        case (state)
            IDLE:    if (start) state_next = TRACK;
            TRACK:   if (valid_in && (stop_a || stop_b)) state_next = HOLD;
            HOLD:    if (spins_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            max_lat          <= '0;
            prev_s           <= '0;
            have_prev        <= 1'b0;
            stable_cnt       <= '0;
            spins_out        <= '0;
            spins_valid      <= 1'b0;
            converged        <= 1'b0;
            iter_count       <= '0;
            total_collisions <= '0;
            busy             <= 1'b0;
        end else begin
            state       <= state_next;
            spins_valid <= (state_next == HOLD);
            busy        <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_count       <= '0;
                        stable_cnt       <= '0;
                        total_collisions <= '0;
                        have_prev        <= 1'b0;
                        converged        <= 1'b0;
                        max_lat          <= max_iters;
                    end
                end
                TRACK: begin
                    if (valid_in) begin
                        iter_count       <= iter_inc;
                        total_collisions <= coll_inc;
                        stable_cnt       <= stable_inc;
                        prev_s           <= s;
                        have_prev        <= 1'b1;
                        if (stop_a || stop_b) begin
                            spins_out <= s;
                            converged <= stop_a;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
